// File: rtl/ddr3_tst_pkg.sv
// ddr3_tst_pkg
// Shared definitions for the DDR3 read-back checker:
//   - checker state encoding (IDLE / CHECK / HALT)
//   - LANE_W: width of one compare lane in bits
//   - LFSR width and tap mask for x^32+x^22+x^2+x+1
//   - pattern helper functions (incrementing lane value, LFSR step)
package ddr3_tst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_HALT  = 2'd2
    } chk_state_t;

    localparam int LANE_W = 16;
    localparam int LFSR_W = 32;

    // Feedback taps at bit positions 31, 21, 1 and 0 (polynomial terms x^32, x^22, x^2, x).
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

    // Incrementing pattern: the lane value of beat n is (base + n) mod 2^16.
    function automatic logic [LANE_W-1:0] inc_lane(input logic [LANE_W-1:0] base,
                                                   input logic [LANE_W-1:0] n);
        return base + n;
    endfunction

    // One Fibonacci LFSR step: shift left, feedback enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ddr3_pattern_gen.sv
// ddr3_pattern_gen
// Holds the expected-pattern state and presents the expected read word for
// the current beat.
// Optional feature macro: DDR3_RDCHK_PRBS_EN (32-bit LFSR pattern instead of
// the incrementing pattern).
// Ports:
//   clk_x1    in  controller user clock
//   rst_n     in  synchronous active-low reset
//   load      in  reload the pattern state from seed
//   advance   in  step to the next beat
//   seed      in  16-bit pattern seed
//   expected  out expected read word for the current beat
module ddr3_pattern_gen
    import ddr3_tst_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  logic              clk_x1,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    input  logic [15:0]       seed,
    output logic [DATA_W-1:0] expected
);

`ifdef DDR3_RDCHK_PRBS_EN
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_seed;

    // An all-zero state would lock the LFSR, so it is replaced by 1.
    always_comb begin
        lfsr_seed = {seed, ~seed};
        if (lfsr_seed == '0) lfsr_seed = 32'h1;
    end

    always_ff @(posedge clk_x1) begin
        if (!rst_n)       lfsr <= '0;
        else if (load)    lfsr <= lfsr_seed;
        else if (advance) lfsr <= lfsr_step(lfsr);
    end

    assign expected = {(DATA_W/LFSR_W){lfsr}};
`else
    logic [LANE_W-1:0] base;
    logic [LANE_W-1:0] n;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_x1) begin
        if (!rst_n) begin
            base <= '0;
            n    <= '0;
        end else if (load) begin
            base <= seed;
            n    <= '0;
        end else if (advance) begin
            n <= n + 1'b1;
        end
    end

    assign expected = {(DATA_W/LANE_W){inc_lane(base, n)}};
`endif

endmodule

// File: rtl/ddr3_rd_checker.sv
// ddr3_rd_checker
// Read-back data checker for the DDR3 1:4 user interface. Every accepted
// read beat is compared lane by lane against a regenerated pattern; results
// appear one cycle after the beat is sampled.
// Optional feature macro: DDR3_RDCHK_PRBS_EN (LFSR pattern, see ddr3_pattern_gen).
// Ports:
//   clk_x1, rst_n         clock and synchronous active-low reset
//   init_calib_complete   checking enabled only while high
//   chk_start, chk_seed   start/restart a run with a new pattern seed
//   rd_data_valid, rd_data read beat (no back-pressure)
//   chk_busy              high in CHECK
//   error_int             one-cycle pulse per mismatching beat
//   error                 sticky mismatch flag
//   err_cnt               saturating mismatch count
//   beat_cnt              wrapping accepted-beat count
//   first_err_beat/mask   beat index and lane mask of the first mismatch
module ddr3_rd_checker
    import ddr3_tst_pkg::*;
#(
    parameter int DATA_W      = 128,
    parameter int CNT_W       = 16,
    parameter int STOP_ON_ERR = 0
) (
    input  logic                     clk_x1,
    input  logic                     rst_n,
    input  logic                     init_calib_complete,
    input  logic                     chk_start,
    input  logic [15:0]              chk_seed,
    input  logic                     rd_data_valid,
    input  logic [DATA_W-1:0]        rd_data,
    output logic                     chk_busy,
    output logic                     error_int,
    output logic                     error,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [CNT_W-1:0]         beat_cnt,
    output logic [CNT_W-1:0]         first_err_beat,
    output logic [DATA_W/LANE_W-1:0] first_err_mask
);

    localparam int LANES = DATA_W / LANE_W;

    chk_state_t        state;
    logic [DATA_W-1:0] expected;
    logic [LANES-1:0]  lane_mask;
    logic              mismatch;
    logic              load;
    logic              accept;

    // chk_start outranks a coincident beat; a calibration drop outranks both.
    assign load     = chk_start && init_calib_complete;
    assign accept   = init_calib_complete && !chk_start && rd_data_valid && (state == ST_CHECK);
    assign mismatch = |lane_mask;
    assign chk_busy = (state == ST_CHECK);

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_mask[i] = rd_data[i*LANE_W +: LANE_W] != expected[i*LANE_W +: LANE_W];
        end
    end

    ddr3_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_pattern_gen (
        .clk_x1   (clk_x1),
        .rst_n    (rst_n),
        .load     (load),
        .advance  (accept),
        .seed     (chk_seed),
        .expected (expected)
    );

    always_ff @(posedge clk_x1) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            error_int      <= 1'b0;
            error          <= 1'b0;
            err_cnt        <= '0;
            beat_cnt       <= '0;
            first_err_beat <= '0;
            first_err_mask <= '0;
        end else begin
            error_int <= 1'b0;
            if (!init_calib_complete) begin
                // Diagnostics are kept so they can be read after calibration loss.
                state <= ST_IDLE;
            end else if (chk_start) begin
                state          <= ST_CHECK;
                error          <= 1'b0;
                err_cnt        <= '0;
                beat_cnt       <= '0;
                first_err_beat <= '0;
                first_err_mask <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (mismatch) begin
                    error_int <= 1'b1;
                    error     <= 1'b1;
                    if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                    if (!error) begin
                        // beat_cnt still holds this beat's index here.
                        first_err_beat <= beat_cnt;
                        first_err_mask <= lane_mask;
                    end
                    if (STOP_ON_ERR != 0) state <= ST_HALT;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr3_rd_checker.sv
// tb_ddr3_rd_checker
// Self-checking bench for ddr3_rd_checker. Two instances share stimulus:
// u_dut0 (STOP_ON_ERR=0) and u_dut1 (STOP_ON_ERR=1). Inputs change on the
// falling edge; each vector's expected outputs are those seen on the falling
// edge after the rising edge that sampled its inputs.
// Optional feature macro: DDR3_RDCHK_PRBS_EN (selects the LFSR reference model).
module tb_ddr3_rd_checker;

    localparam int DATA_W = 128;
    localparam int CNT_W  = 16;
    localparam int LANES  = 8;

    logic               clk_x1 = 1'b0;
    logic               rst_n;
    logic               calib;
    logic               start;
    logic [15:0]        seed;
    logic               valid;
    logic [DATA_W-1:0]  rd_data;

    logic               busy0, eint0, err0;
    logic [CNT_W-1:0]   ecnt0, bcnt0, fbeat0;
    logic [LANES-1:0]   fmask0;
    logic               busy1, eint1, err1;
    logic [CNT_W-1:0]   ecnt1, bcnt1, fbeat1;
    logic [LANES-1:0]   fmask1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_x1 = ~clk_x1;

    ddr3_rd_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W), .STOP_ON_ERR(0)) u_dut0 (
        .clk_x1 (clk_x1), .rst_n (rst_n), .init_calib_complete (calib),
        .chk_start (start), .chk_seed (seed), .rd_data_valid (valid), .rd_data (rd_data),
        .chk_busy (busy0), .error_int (eint0), .error (err0), .err_cnt (ecnt0),
        .beat_cnt (bcnt0), .first_err_beat (fbeat0), .first_err_mask (fmask0)
    );

    ddr3_rd_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W), .STOP_ON_ERR(1)) u_dut1 (
        .clk_x1 (clk_x1), .rst_n (rst_n), .init_calib_complete (calib),
        .chk_start (start), .chk_seed (seed), .rd_data_valid (valid), .rd_data (rd_data),
        .chk_busy (busy1), .error_int (eint1), .error (err1), .err_cnt (ecnt1),
        .beat_cnt (bcnt1), .first_err_beat (fbeat1), .first_err_mask (fmask1)
    );

    // ---------------- reference pattern model ----------------
`ifdef DDR3_RDCHK_PRBS_EN
    function automatic logic [31:0] m_load(input logic [15:0] s);
        logic [31:0] v;
        v = {s, ~s};
        return (v == 32'h0) ? 32'h1 : v;
    endfunction
    function automatic logic [31:0] m_step(input logic [31:0] s);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], fb};
    endfunction
    function automatic logic [DATA_W-1:0] m_word(input logic [31:0] s);
        return {4{s}};
    endfunction
`else
    function automatic logic [31:0] m_load(input logic [15:0] s);
        return {16'h0, s};
    endfunction
    function automatic logic [31:0] m_step(input logic [31:0] s);
        return {16'h0, s[15:0] + 16'd1};
    endfunction
    function automatic logic [DATA_W-1:0] m_word(input logic [31:0] s);
        return {8{s[15:0]}};
    endfunction
`endif

    // Expected word of beat idx of a run seeded with sd, optionally with bit 0 of one lane flipped.
    function automatic logic [DATA_W-1:0] beat_word(input logic [15:0] sd, input int idx, input int bad);
        logic [31:0]       s;
        logic [DATA_W-1:0] w;
        s = m_load(sd);
        for (int i = 0; i < idx; i++) s = m_step(s);
        w = m_word(s);
        if (bad >= 0) w[bad*16] = ~w[bad*16];
        return w;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_dut1(input string tag, input logic busy, input logic eint, input logic err,
                              input logic [15:0] ecnt, input logic [15:0] bcnt,
                              input logic [15:0] fbeat, input logic [7:0] fmask);
        check({tag, " busy"},  32'(busy1),  32'(busy));
        check({tag, " eint"},  32'(eint1),  32'(eint));
        check({tag, " err"},   32'(err1),   32'(err));
        check({tag, " ecnt"},  32'(ecnt1),  32'(ecnt));
        check({tag, " bcnt"},  32'(bcnt1),  32'(bcnt));
        check({tag, " fbeat"}, 32'(fbeat1), 32'(fbeat));
        check({tag, " fmask"}, 32'(fmask1), 32'(fmask));
    endtask

    // One cycle of stimulus; returns at the next falling edge.
    task automatic step(input logic st, input logic vl, input logic [15:0] sd, input logic [DATA_W-1:0] d);
        start   = st;
        valid   = vl;
        seed    = sd;
        rd_data = d;
        @(negedge clk_x1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        cal;
        logic        st;
        logic        vld;
        logic [15:0] sd;
        int          idx;
        int          bad;
        logic        busy;
        logic        eint;
        logic        err;
        logic [15:0] ecnt;
        logic [15:0] bcnt;
        logic [15:0] fbeat;
        logic [7:0]  fmask;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic c, input logic s, input logic v,
                                input logic [15:0] sd, input int idx, input int bad,
                                input logic busy, input logic eint, input logic err,
                                input logic [15:0] ecnt, input logic [15:0] bcnt,
                                input logic [15:0] fbeat, input logic [7:0] fmask);
        vec_t x;
        x.rst = r; x.cal = c; x.st = s; x.vld = v; x.sd = sd; x.idx = idx; x.bad = bad;
        x.busy = busy; x.eint = eint; x.err = err; x.ecnt = ecnt; x.bcnt = bcnt;
        x.fbeat = fbeat; x.fmask = fmask;
        return x;
    endfunction

    initial begin
        logic [15:0]       run_seed;
        logic [31:0]       s;
        string             tag;

        rst_n = 1'b0; calib = 1'b0; start = 1'b0; valid = 1'b0; seed = '0; rd_data = '0;
        run_seed = '0;

        //              rst cal st vld seed     idx bad  busy eint err ecnt bcnt fbeat fmask
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, -1,  0, 0, 0, 0, 0, 0, 8'h00));
        // Calibration low: start and beats are ignored.
        vecs.push_back(mk(1, 0, 1, 0, 16'h1234, 0, -1,  0, 0, 0, 0, 0, 0, 8'h00));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 0, 0, 1, 16'h0, i, -1, 0, 0, 0, 0, 0, 0, 8'h00));
        // Seed 1000, eight clean beats.
        vecs.push_back(mk(1, 1, 1, 0, 16'h1000, 0, -1,  1, 0, 0, 0, 0, 0, 8'h00));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 1, 0, 1, 16'h0, i, -1, 1, 0, 0, 0, 16'(i+1), 0, 8'h00));
        // Seed 0000, lane 3 of beat 5 corrupted, then beats 9 and 10 back to back.
        vecs.push_back(mk(1, 1, 1, 0, 16'h0000, 0, -1,  1, 0, 0, 0, 0, 0, 8'h00));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 1, 0, 1, 16'h0, i, -1, 1, 0, 0, 0, 16'(i+1), 0, 8'h00));
        vecs.push_back(mk(1, 1, 0, 1, 16'h0, 5,  3,     1, 1, 1, 1, 6,  5, 8'h08));
        vecs.push_back(mk(1, 1, 0, 1, 16'h0, 6, -1,     1, 0, 1, 1, 7,  5, 8'h08));
        vecs.push_back(mk(1, 1, 0, 1, 16'h0, 7, -1,     1, 0, 1, 1, 8,  5, 8'h08));
        vecs.push_back(mk(1, 1, 0, 1, 16'h0, 8, -1,     1, 0, 1, 1, 9,  5, 8'h08));
        vecs.push_back(mk(1, 1, 0, 1, 16'h0, 9,  0,     1, 1, 1, 2, 10, 5, 8'h08));
        vecs.push_back(mk(1, 1, 0, 1, 16'h0, 10, 7,     1, 1, 1, 3, 11, 5, 8'h08));
        vecs.push_back(mk(1, 1, 0, 1, 16'h0, 11, -1,    1, 0, 1, 3, 12, 5, 8'h08));
        vecs.push_back(mk(1, 1, 0, 0, 16'h0, 0, -1,     1, 0, 1, 3, 12, 5, 8'h08));
        // Wrap of the incrementing pattern: lanes FFFE, FFFF, 0000, 0001.
        vecs.push_back(mk(1, 1, 1, 0, 16'hFFFE, 0, -1,  1, 0, 0, 0, 0, 0, 8'h00));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 1, 0, 1, 16'h0, i, -1, 1, 0, 0, 0, 16'(i+1), 0, 8'h00));
        // Error then calibration loss: diagnostics retained, later beats ignored.
        vecs.push_back(mk(1, 1, 1, 0, 16'h0050, 0, -1,  1, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 1, 0, 1, 16'h0, 0, -1,     1, 0, 0, 0, 1, 0, 8'h00));
        vecs.push_back(mk(1, 1, 0, 1, 16'h0, 1,  1,     1, 1, 1, 1, 2, 1, 8'h02));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0, 2,  2,     0, 0, 1, 1, 2, 1, 8'h02));
        vecs.push_back(mk(1, 1, 0, 1, 16'h0, 2,  2,     0, 0, 1, 1, 2, 1, 8'h02));
        // One-cycle reset clears everything.
        vecs.push_back(mk(0, 1, 0, 0, 16'h0, 0, -1,     0, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 1, 0, 0, 16'h0, 0, -1,     0, 0, 0, 0, 0, 0, 8'h00));

        @(negedge clk_x1);
        foreach (vecs[i]) begin
            rst_n = vecs[i].rst;
            calib = vecs[i].cal;
            rd_data = vecs[i].vld ? beat_word(run_seed, vecs[i].idx, vecs[i].bad) : '0;
            if (vecs[i].st) run_seed = vecs[i].sd;
            step(vecs[i].st, vecs[i].vld, vecs[i].sd, rd_data);
            tag = $sformatf("v%0d", i);
            check({tag, " busy"},  32'(busy0),  32'(vecs[i].busy));
            check({tag, " eint"},  32'(eint0),  32'(vecs[i].eint));
            check({tag, " err"},   32'(err0),   32'(vecs[i].err));
            check({tag, " ecnt"},  32'(ecnt0),  32'(vecs[i].ecnt));
            check({tag, " bcnt"},  32'(bcnt0),  32'(vecs[i].bcnt));
            check({tag, " fbeat"}, 32'(fbeat0), 32'(vecs[i].fbeat));
            check({tag, " fmask"}, 32'(fmask0), 32'(vecs[i].fmask));
        end

        // ---- err_cnt saturation and beat_cnt wrap: 2^16+3 mismatching beats ----
        rst_n = 1'b1; calib = 1'b1;
        step(1'b1, 1'b0, 16'h0042, '0);
        s = m_load(16'h0042);
        for (int k = 0; k < 65539; k++) begin
            step(1'b0, 1'b1, 16'h0, ~m_word(s));
            s = m_step(s);
        end
        check("sat eint",  32'(eint0),  32'h1);
        check("sat ecnt",  32'(ecnt0),  32'hFFFF);
        check("sat bcnt",  32'(bcnt0),  32'h3);
        check("sat fbeat", 32'(fbeat0), 32'h0);
        check("sat fmask", 32'(fmask0), 32'hFF);

        // ---- STOP_ON_ERR=1: mismatch at beat 2 halts the run ----
        step(1'b1, 1'b0, 16'h2000, '0);
        step(1'b0, 1'b1, 16'h0, beat_word(16'h2000, 0, -1));
        step(1'b0, 1'b1, 16'h0, beat_word(16'h2000, 1, -1));
        step(1'b0, 1'b1, 16'h0, beat_word(16'h2000, 2, 4));
        check_dut1("halt edge", 0, 1, 1, 1, 3, 2, 8'h10);
        for (int i = 3; i < 8; i++) step(1'b0, 1'b1, 16'h0, beat_word(16'h2000, i, -1));
        check_dut1("halt hold", 0, 0, 1, 1, 3, 2, 8'h10);
        // Restart with a coincident (bad) beat: the beat is ignored.
        step(1'b1, 1'b1, 16'h3000, beat_word(16'h3000, 0, 5));
        check_dut1("restart", 1, 0, 0, 0, 0, 0, 8'h00);
        step(1'b0, 1'b1, 16'h0, beat_word(16'h3000, 0, -1));
        check_dut1("restart beat0", 1, 0, 0, 0, 1, 0, 8'h00);

`ifdef DDR3_RDCHK_PRBS_EN
        // ---- LFSR pattern: seed 0 loads 32'h0000_FFFF ----
        step(1'b1, 1'b0, 16'h0000, '0);
        step(1'b0, 1'b1, 16'h0, {4{32'h0000_FFFF}});
        for (int i = 1; i < 64; i++) step(1'b0, 1'b1, 16'h0, beat_word(16'h0000, i, -1));
        check("prbs clean err",  32'(err0),  32'h0);
        check("prbs clean bcnt", 32'(bcnt0), 32'd64);
        step(1'b1, 1'b0, 16'h0000, '0);
        step(1'b0, 1'b1, 16'h0, {4{32'h0000_FFFF}});
        for (int i = 1; i < 16; i++)
            step(1'b0, 1'b1, 16'h0, beat_word(16'h0000, i, (i == 10) ? 0 : -1));
        check("prbs ecnt",  32'(ecnt0),  32'h1);
        check("prbs fbeat", 32'(fbeat0), 32'd10);
        check("prbs fmask", 32'(fmask0), 32'h01);
`endif

        step(1'b0, 1'b0, 16'h0, '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr3_rd_checker.md
Name: ddr3_rd_checker

Overview:
- Read-back data checker on the DDR3 1:4 user interface; consumes read-data beats from the memory controller and compares each against a locally regenerated expected pattern.
- Produces the per-beat mismatch pulse, sticky error flag and diagnostics consumed by the test top and the on-chip logic-analyzer probe (trigger on error_int, data on error/init_calib_complete).
- Runs entirely in the controller user clock domain.

Parameters:
- DATA_W, 128, read-data width in bits; must be a multiple of 16.
- CNT_W, 16, width of the error counter and beat counter.
- STOP_ON_ERR, 0, 1 = halt checking after the first mismatch; 0 = keep checking.

Ports:
- clk_x1  in  1  controller user clock; the only clock.
- rst_n  in  1  synchronous active-low reset.
- init_calib_complete  in  1  DDR3 calibration done; checking is only enabled while high.
- chk_start  in  1  single-cycle pulse; starts or restarts a check run.
- chk_seed  in  16  pattern base value, sampled on chk_start.
- rd_data_valid  in  1  read beat valid; no back-pressure, so every valid beat must be accepted.
- rd_data  in  DATA_W  read beat data.
- chk_busy  out  1  high in the CHECK state.
- error_int  out  1  one-cycle pulse: the previous accepted beat mismatched.
- error  out  1  sticky mismatch flag.
- err_cnt  out  CNT_W  count of mismatching beats; saturates.
- beat_cnt  out  CNT_W  count of accepted beats; wraps.
- first_err_beat  out  CNT_W  beat index of the first mismatch.
- first_err_mask  out  DATA_W/16  per-16-bit-lane mismatch mask of the first mismatching beat.

Behaviour:
- Reset (rst_n low at a clk_x1 edge): state IDLE; all outputs 0; internal pattern register 0.
- States:
  - IDLE: leaves to CHECK on chk_start when init_calib_complete=1. chk_start while calib is low is ignored.
  - CHECK: accepts beats.
  - HALT: reached only when STOP_ON_ERR=1, on the first mismatch. Beats are ignored and chk_busy=0.
  - From any state, chk_start with init_calib_complete=1 goes to CHECK.
  - init_calib_complete falling goes to IDLE from any state. error, err_cnt and the first_err_* outputs are retained; beat_cnt is retained.
- chk_start effect, same edge: clears error, err_cnt, beat_cnt, first_err_*; beat index n := 0; base := chk_seed. A simultaneous rd_data_valid beat is ignored (chk_start has priority).
- Expected beat n (default pattern): every 16-bit lane = (base + n) mod 2^16. n increments on each accepted beat and is independent of CNT_W.
- Accepted beat: rd_data_valid=1 in CHECK and not chk_start.
  - lane mismatch mask = per-lane compare of rd_data against the expected word.
  - mismatch = OR of the mask.
- Latency: compare is registered.
  - error_int, error set, err_cnt++ and beat_cnt++ all take effect on the edge after the accepted beat is sampled (1-cycle latency).
  - error_int is high for exactly one cycle per mismatching beat; back-to-back mismatches give a continuously high error_int.
- first_err_beat/first_err_mask load only when error was 0 before this mismatch.
- err_cnt saturates at all-ones. beat_cnt wraps to 0.
- Beats with rd_data_valid=1 in IDLE or HALT: no effect on any output.
- STOP_ON_ERR=1: the transition to HALT occurs on the same edge as the error_int pulse.

Optional Feature:
- Macro DDR3_RDCHK_PRBS_EN.
- Defined: expected pattern comes from a 32-bit Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1.
  - Seeded with {chk_seed, ~chk_seed} on chk_start; a zero seed is forced to 32'h1.
  - Steps once per accepted beat.
  - Expected word = LFSR state replicated across DATA_W/32 lanes, so DATA_W must also be a multiple of 32.
  - first_err_mask still reports per 16-bit lane.
- Not defined: the incrementing pattern above, and no LFSR logic is synthesised.

Decomposition:
- Shared package ddr3_tst_pkg:
  - state encoding (IDLE/CHECK/HALT)
  - LANE_W=16 constant
  - LFSR polynomial/tap constant
  - function computing the expected word from base/n or LFSR state
- One natural sub-module: ddr3_pattern_gen, holding the pattern state register. Inputs: load, advance, seed. Output: expected word.
- Checker FSM, compare and counters stay in ddr3_rd_checker.

Test Plan:
- Hold calib=0, pulse chk_start, drive 4 valid beats -> chk_busy stays 0, all outputs stay 0. Raise calib, chk_start with seed 16'h1000, drive 8 correct beats (lanes 16'h1000..16'h1007) -> beat_cnt=8, error=0, err_cnt=0.
- Seed 16'h0000; corrupt lane 3 of beat 5 -> error_int pulses exactly once, 1 cycle after beat 5; error=1 sticky; err_cnt=1; first_err_beat=5; first_err_mask=8'b0000_1000.
- Further mismatches at beats 9 and 10 -> err_cnt=3; first_err_* unchanged. Force 2^CNT_W+3 mismatches -> err_cnt=16'hFFFF.
- STOP_ON_ERR=1: mismatch at beat 2, then 5 more beats -> HALT entered and chk_busy=0 on the error_int edge; beat_cnt=3; err_cnt=1. Then chk_start plus a simultaneous valid beat -> all counters 0, that beat ignored, state CHECK.
- Drop calib mid-run after an error -> state IDLE, error stays 1, later beats ignored. Apply rst_n=0 for one cycle -> all outputs 0. Wrap check: seed 16'hFFFE, beats 0..3 expect lanes FFFE, FFFF, 0000, 0001 -> no error.
- With DDR3_RDCHK_PRBS_EN: seed 16'h0000 -> LFSR loads 32'h0000_FFFF. Drive a reference-model sequence of 64 beats -> no error. Flip bit 0 of beat 10 -> first_err_mask=8'b0000_0001, first_err_beat=10.
